// File: rtl/inst_prefetch_fifo_if.sv
// Instruction prefetch bundle: fetch request/response bus
// plus the decoded-side instruction handshake.
interface inst_prefetch_fifo_if;
  logic [31:0] ibus_addr_o;
  logic        ibus_req_valid_o;
  logic        ibus_req_ready_i;
  logic [31:0] ibus_data_i;
  logic        ibus_rsp_valid_i;
  logic        ibus_rsp_ready_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  modport master (
    output ibus_addr_o,
    output ibus_req_valid_o,
    input  ibus_req_ready_i,
    input  ibus_data_i,
    input  ibus_rsp_valid_i,
    output ibus_rsp_ready_o,
    output inst_o,
    output pc_o,
    output inst_valid_o,
    input  inst_ready_i
  );

  modport slave (
    input  ibus_addr_o,
    input  ibus_req_valid_o,
    output ibus_req_ready_i,
    output ibus_data_i,
    output ibus_rsp_valid_i,
    input  ibus_rsp_ready_o,
    input  inst_o,
    input  pc_o,
    input  inst_valid_o,
    output inst_ready_i
  );
endinterface

// File: rtl/inst_prefetch_fifo.sv
// Instruction prefetch queue: issues sequential fetches only
// when a slot is reserved, drops stale responses after flush.
module inst_prefetch_fifo #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [31:0]          flush_addr_i,
  input  logic                 halt_i,
  inst_prefetch_fifo_if.master bus,
  output logic [CW-1:0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 2;

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   mem_q [DEPTH];

  logic [SW-1:0] inflight;
  logic          has_slot;
  logic          req_valid;
  logic          req_xfer;
  logic          rsp_xfer;
  logic          dropping;
  logic          keep;
  logic          inst_valid;
  logic          pop;
  logic [31:0]   flush_pc;
  logic [31:0]   head_pc;

  // Every entry queued or on the bus already owns a slot.
  assign inflight = SW'(count_q) + SW'(outst_q) + SW'(disc_q);
  assign has_slot = inflight < SW'(DEPTH);

  assign req_valid = rst_n & ~flush_i & ~halt_i & has_slot;
  assign req_xfer  = req_valid & bus.ibus_req_ready_i;
  assign rsp_xfer  = bus.ibus_rsp_valid_i;
  assign dropping  = disc_q != '0;
  assign keep      = rsp_xfer & ~dropping & ~flush_i;

  assign inst_valid = rst_n & (count_q != '0) & ~flush_i;
  assign pop        = inst_valid & bus.inst_ready_i;

  assign flush_pc = {flush_addr_i[31:2], 2'b00};

  // Queue holds a contiguous run ending just below rsp_pc.
  assign head_pc = rsp_pc_q - {count_q, 2'b00};

  always_comb begin
    count_d    = count_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (flush_i) begin
      count_d    = '0;
      outst_d    = '0;
      disc_d     = disc_q + outst_q
                 - CW'(rsp_xfer);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = flush_pc;
      rsp_pc_d   = flush_pc;
    end else begin
      count_d  = count_q + CW'(keep)
               - CW'(pop);
      outst_d  = outst_q + CW'(req_xfer)
               - CW'(rsp_xfer & ~dropping);
      disc_d   = disc_q
               - CW'(rsp_xfer & dropping);
      wr_ptr_d = wr_ptr_q + PW'(keep);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (req_xfer)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (keep)
        rsp_pc_d = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
    end else begin
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (keep)
      mem_q[wr_ptr_q] <= bus.ibus_data_i;
  end

  assign bus.ibus_addr_o      = fetch_pc_q;
  assign bus.ibus_req_valid_o = req_valid;
  assign bus.ibus_rsp_ready_o = 1'b1;
  assign bus.inst_valid_o     = inst_valid;
  assign bus.inst_o = inst_valid ? mem_q[rd_ptr_q]
                                 : 32'h0;
  assign bus.pc_o   = inst_valid ? head_pc : 32'h0;
  assign count_o    = count_q;

endmodule

// File: tb/tb_inst_prefetch_fifo.sv
// Bench for inst_prefetch_fifo: fixed vectors, corner
// sequences and a random run against a tagged in-flight model.
module tb_inst_prefetch_fifo;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic [31:0]   flush_addr_i = '0;
  logic          halt_i = 1'b0;
  logic [CW-1:0] count_o;

  inst_prefetch_fifo_if bus ();

  inst_prefetch_fifo #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .flush_addr_i(flush_addr_i),
    .halt_i      (halt_i),
    .bus         (bus.master),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  // A fetch on the bus, tagged stale once a flush overtakes it.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit          ir;
    int          cnt;
    bit          rv;
    logic [31:0] addr;
  } vec_t;

  fl_t         bus_q[$];
  ent_t        fifo_q[$];
  logic [31:0] exp_fpc = RPC;
  int          tests = 0;
  int          fails = 0;
  bit          await_first = 1'b0;
  bit          got_first = 1'b0;
  logic [31:0] first_pc = '0;
  vec_t        tbl[12];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step(input bit fl,
                      input logic [31:0] fa,
                      input bit hl, input bit ir,
                      input bit qr, input bit re,
                      output int s_cnt,
                      output bit s_rv,
                      output logic [31:0] s_addr);
    fl_t  f;
    ent_t e;
    bit   rv, rx, qx, px;
    int   occ;
    flush_i = fl;
    flush_addr_i = fa;
    halt_i = hl;
    bus.inst_ready_i = ir;
    bus.ibus_req_ready_i = qr;
    rv = re && (bus_q.size() > 0);
    bus.ibus_rsp_valid_i = rv;
    bus.ibus_data_i = rv ? (bus_q[0].addr ^ KEY)
                         : 32'hDEAD_BEEF;
    @(negedge clk);
    occ = fifo_q.size() + bus_q.size();
    chk("count_o", 32'(count_o), 32'(fifo_q.size()));
    chk("count_bound", 32'(count_o <= CW'(DEPTH)), 32'd1);
    chk("inst_valid", 32'(bus.inst_valid_o),
        32'(!fl && fifo_q.size() > 0));
    chk("req_valid", 32'(bus.ibus_req_valid_o),
        32'(!fl && !hl && occ < DEPTH));
    chk("rsp_ready", 32'(bus.ibus_rsp_ready_o), 32'd1);
    chk("ibus_addr", bus.ibus_addr_o, exp_fpc);
    if (bus.inst_valid_o && fifo_q.size() > 0) begin
      chk("pc_o", bus.pc_o, fifo_q[0].pc);
      chk("inst_o", bus.inst_o, fifo_q[0].inst);
    end
    s_cnt  = int'(count_o);
    s_rv   = bus.ibus_req_valid_o;
    s_addr = bus.ibus_addr_o;
    rx = rv && bus.ibus_rsp_ready_o;
    qx = bus.ibus_req_valid_o && qr;
    px = bus.inst_valid_o && ir;
    f = '{addr: 32'h0, stale: 1'b1};
    if (rx) f = bus_q.pop_front();
    if (fl) begin
      fifo_q.delete();
      foreach (bus_q[i]) bus_q[i].stale = 1'b1;
      exp_fpc = {fa[31:2], 2'b00};
    end else begin
      if (px && fifo_q.size() > 0) begin
        if (await_first) begin
          first_pc = fifo_q[0].pc;
          got_first = 1'b1;
          await_first = 1'b0;
        end
        void'(fifo_q.pop_front());
      end
      if (rx && !f.stale) begin
        e.pc = f.addr;
        e.inst = f.addr ^ KEY;
        fifo_q.push_back(e);
      end
      if (qx) begin
        bus_q.push_back('{addr: bus.ibus_addr_o,
                          stale: 1'b0});
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          c;
  bit          v;
  logic [31:0] a;

  initial begin
    tbl[0]  = '{1'b0, 0, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 0, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 1, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 2, 1'b1, 32'h0C};
    tbl[4]  = '{1'b0, 3, 1'b0, 32'h10};
    tbl[5]  = '{1'b0, 4, 1'b0, 32'h10};
    tbl[6]  = '{1'b0, 4, 1'b0, 32'h10};
    tbl[7]  = '{1'b1, 4, 1'b0, 32'h10};
    tbl[8]  = '{1'b1, 3, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 2, 1'b1, 32'h14};
    tbl[10] = '{1'b1, 2, 1'b1, 32'h18};
    tbl[11] = '{1'b1, 2, 1'b1, 32'h1C};

    bus.inst_ready_i = 1'b0;
    bus.ibus_req_ready_i = 1'b1;
    bus.ibus_rsp_valid_i = 1'b0;
    bus.ibus_data_i = '0;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.ibus_req_valid_o), 0);
    chk("rst_inst_valid", 32'(bus.inst_valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_addr", bus.ibus_addr_o, RPC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill with consumer stalled, then drain in order
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b0, tbl[i].ir, 1'b1, 1'b1,
           c, v, a);
      chk($sformatf("vec%0d_count", i), 32'(c),
          32'(tbl[i].cnt));
      chk($sformatf("vec%0d_rv", i), 32'(v),
          32'(tbl[i].rv));
      chk($sformatf("vec%0d_addr", i), a, tbl[i].addr);
    end

    // three outstanding, then flush to unaligned target
    repeat (8) step(0, '0, 0, 1, 0, 1, c, v, a);
    repeat (3) step(0, '0, 0, 1, 1, 0, c, v, a);
    step(1, 32'h103, 0, 1, 1, 0, c, v, a);
    chk("flush_rv", 32'(v), 0);
    await_first = 1'b1;
    got_first = 1'b0;
    step(0, '0, 0, 1, 1, 0, c, v, a);
    chk("flush_addr", a, 32'h100);
    repeat (12) step(0, '0, 0, 1, 1, 1, c, v, a);
    chk("flush_first_seen", 32'(got_first), 1);
    chk("flush_first_pc", first_pc, 32'h100);

    // flush colliding with a response and a pop
    repeat (2) step(0, '0, 0, 0, 1, 1, c, v, a);
    step(1, 32'h200, 0, 1, 1, 1, c, v, a);
    step(0, '0, 0, 1, 1, 0, c, v, a);
    chk("flush_coll_count", 32'(c), 0);
    chk("flush_coll_addr", a, 32'h200);

    // halt with two fetches in flight
    repeat (8) step(0, '0, 0, 1, 0, 1, c, v, a);
    repeat (2) step(0, '0, 0, 0, 1, 0, c, v, a);
    repeat (6) begin
      step(0, '0, 1, 0, 1, 1, c, v, a);
      chk("halt_rv", 32'(v), 0);
    end
    chk("halt_count", 32'(c), 2);
    step(0, '0, 0, 1, 1, 1, c, v, a);
    chk("halt_release_rv", 32'(v), 1);
    repeat (10) step(0, '0, 0, 1, 1, 1, c, v, a);

    // random stalls, halts and flushes
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(63) == 0, $urandom(),
           $urandom_range(7) == 0,
           $urandom_range(9) < 7,
           $urandom_range(9) < 7,
           $urandom_range(9) < 7, c, v, a);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
